shift_reg_ctrl: RTL

Sequencing controller for the lab shift-register datapath. It captures operation requests from the debounced one-shot button pulses and arbitrates between them round-robin. It then executes the granted operation (parallel load, shift left, shift right, rotate left) on an internal WIDTH-bit register over one or more clock cycles. It also generates the periodic sample tick that paces the button debouncers.

---
 rtl/shift_reg_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_reg_ctrl.sv
// Shift-register sequencing controller: edge-captured requests, round-robin
// arbitration, multi-cycle load/shift/rotate execution and a debounce tick.
module shift_reg_ctrl #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 3,
  parameter int TICK_DIV = 1000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d_load,
  input  logic             sin,
  input  logic [CNT_W-1:0] amt,
  output logic             tick,
  output logic [WIDTH-1:0] q,
  output logic [3:0]       grant,
  output logic             busy,
  output logic             done
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  // Encoding matches the request bit index so the winner maps straight to an op.
  typedef enum logic [1:0] {OP_LOAD, OP_SHL, OP_SHR, OP_ROTL} op_e;

  state_e           state, state_n;
  op_e              op;
  logic [3:0]       req_hist, pending, clr, grant_n;
  logic [1:0]       ptr, win_idx;
  logic             win_valid, start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d_lat;
  logic [TW-1:0]    tick_cnt;

  // Round-robin search beginning just after the last winner.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every combinationally written signal gets a default first, so no latch is inferred.
    win_valid = 1'b0;
    win_idx   = ptr;
    idx       = ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!win_valid && pending[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = '0;
    clr     = '0;
    start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_valid) begin
          grant_n[win_idx] = 1'b1;
          clr[win_idx]     = 1'b1;
          start            = 1'b1;
          state_n = (win_idx != 2'(OP_LOAD) && amt == '0) ? S_DONE : S_EXEC;
        end
      end
      S_EXEC:  if (cnt == CNT_W'(1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_n;
      grant <= grant_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state_n == S_DONE);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      req_hist <= '0;
      pending  <= '0;
      ptr      <= 2'd3;
      op       <= OP_LOAD;
      cnt      <= '0;
      d_lat    <= '0;
      q        <= '0;
    end else begin
      req_hist <= req;
      // A fresh edge in the grant cycle re-arms the bit being cleared.
      pending  <= (pending & ~clr) | (req & ~req_hist);
      if (start) begin
        ptr   <= win_idx;
        op    <= op_e'(win_idx);
        cnt   <= (win_idx == 2'(OP_LOAD)) ? CNT_W'(1) : amt;
        d_lat <= d_load;
      end
      if (state == S_EXEC) begin
        cnt <= cnt - CNT_W'(1);
        case (op)
          OP_LOAD: q <= d_lat;
          OP_SHL:  q <= {q[WIDTH-2:0], sin};
          OP_SHR:  q <= {sin, q[WIDTH-1:1]};
          OP_ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]};
          default: q <= q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                               tick_cnt <= '0;
    else if (tick_cnt == TW'(TICK_DIV - 1)) tick_cnt <= '0;
    else                                    tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

endmodule
